microondas_ctrl_param: RTL and testbench

Parametrised successor microwave controller: time entry, power selection, countdown and door interlock for one cooking chamber, with heater duty-cycle control, add-30s during cooking, and a timed DONE/buzzer phase. It generates its own 1 Hz tick from CLK_FREQ. It outputs binary min/sec, power level and state for the separate display block.

---
 rtl/microondas_pkg.sv | 23 ++
 rtl/microondas_ctrl_param_edge_detector.sv | 28 ++
 rtl/microondas_ctrl_param.sv | 229 ++++++++++++++++++++++
 tb/tb_microondas_ctrl_param.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave controller slice.
//   state_e : controller state, also driven out on the 2-bit state port
//   sel_e   : edit field chosen by the sel input
//   SEC_MAX : largest legal seconds value
package microondas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEC_U = 2'd0,
    SEL_SEC_T = 2'd1,
    SEL_MIN_U = 2'd2,
    SEL_MIN_T = 2'd3
  } sel_e;

  localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/microondas_ctrl_param_edge_detector.sv
// Registered rising-edge detector for one raw button.
//   clock  : system clock
//   reset  : synchronous, active-low
//   din    : raw button level
//   rising : one-cycle pulse, one cycle after din rises
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rising
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= din;
      rise_q <= din & ~prev_q;
    end
  end

  assign rising = rise_q;

endmodule

// File: rtl/microondas_ctrl_param.sv
// Microwave controller: time entry, power level, countdown with internal
// 1 Hz tick, door interlock, heater duty cycling, add-QUICK_SEC and a timed
// DONE/buzzer phase.
//   clock, reset        : clock and synchronous active-low reset
//   start/stop/pause    : raw buttons (edge detected internally)
//   plus/minus          : raw buttons, edit time or power level
//   door                : 1 = door open
//   sel, power_mode     : edit field select, power-adjust mode
//   min, sec, level     : programmed/remaining time and power level
//   heater, buzzer, done: magnetron enable, DONE buzzer, DONE entry pulse
//   state               : IDLE=0 RUN=1 PAUSE=2 DONE=3
module microondas_ctrl_param
  import microondas_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned DONE_SECS  = 3,
  parameter int unsigned QUICK_SEC  = 30
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              pause,
  input  logic                              plus,
  input  logic                              minus,
  input  logic                              door,
  input  logic [1:0]                        sel,
  input  logic                              power_mode,
  output logic [$clog2(MAX_MIN+1)-1:0]      min,
  output logic [5:0]                        sec,
  output logic [$clog2(NUM_LEVELS)-1:0]     level,
  output logic                              heater,
  output logic                              buzzer,
  output logic                              done,
  output logic [1:0]                        state
);

  localparam int unsigned MW = $clog2(MAX_MIN + 1);
  localparam int unsigned LW = $clog2(NUM_LEVELS);
  localparam int unsigned TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned DW = $clog2(DONE_SECS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_FREQ - 1);
  localparam logic [LW-1:0] LVL_TOP    = LW'(NUM_LEVELS - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_SECS - 1);
  localparam logic [31:0]   MAX_M      = 32'(MAX_MIN);
  localparam logic [31:0]   Q_MIN      = 32'(QUICK_SEC / 60);
  localparam logic [31:0]   Q_SEC      = 32'(QUICK_SEC % 60);

  logic start_p, stop_p, pause_p, plus_p, minus_p;

  edge_detector u_ed_start (.clock(clock), .reset(reset), .din(start), .rising(start_p));
  edge_detector u_ed_stop  (.clock(clock), .reset(reset), .din(stop),  .rising(stop_p));
  edge_detector u_ed_pause (.clock(clock), .reset(reset), .din(pause), .rising(pause_p));
  edge_detector u_ed_plus  (.clock(clock), .reset(reset), .din(plus),  .rising(plus_p));
  edge_detector u_ed_minus (.clock(clock), .reset(reset), .din(minus), .rising(minus_p));

  state_e          state_q, state_d;
  logic [MW-1:0]   min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [LW-1:0]   duty_q, duty_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            heater_q, done_q;
  logic            tick;

  // Candidate time values for every kind of update; the FSM picks one.
  logic [MW-1:0] edit_min, add_min, tick_min;
  logic [5:0]    edit_sec, add_sec, tick_sec;
  logic          tick_zero, field_min;
  logic [31:0]   min_w, sec_w, step_w, sec_sum, min_sum;

  always_comb begin
    min_w     = 32'(min_q);
    sec_w     = 32'(sec_q);
    field_min = (sel_e'(sel) == SEL_MIN_U) || (sel_e'(sel) == SEL_MIN_T);
    step_w    = ((sel_e'(sel) == SEL_SEC_T) || (sel_e'(sel) == SEL_MIN_T)) ? 32'd10 : 32'd1;
    edit_min  = min_q;
    edit_sec  = sec_q;
    if (plus_p) begin
      if (field_min) edit_min = MW'((min_w + step_w > MAX_M) ? MAX_M : min_w + step_w);
      else           edit_sec = 6'((sec_w + step_w > SEC_MAX) ? SEC_MAX : sec_w + step_w);
    end else if (minus_p) begin
      if (field_min) edit_min = MW'((min_w < step_w) ? 32'd0 : min_w - step_w);
      else           edit_sec = 6'((sec_w < step_w) ? 32'd0 : sec_w - step_w);
    end

    sec_sum = sec_w + Q_SEC;
    min_sum = min_w + Q_MIN;
    if (sec_sum >= 32'd60) begin
      sec_sum = sec_sum - 32'd60;
      min_sum = min_sum + 32'd1;
    end
    if (min_sum > MAX_M) begin
      add_min = MW'(MAX_M);
      add_sec = 6'(SEC_MAX);
    end else begin
      add_min = MW'(min_sum);
      add_sec = 6'(sec_sum);
    end

    if (sec_q != '0) begin
      tick_min = min_q;
      tick_sec = sec_q - 6'd1;
    end else begin
      tick_min = min_q - MW'(1);
      tick_sec = 6'(SEC_MAX);
    end
    tick_zero = (tick_min == '0) && (tick_sec == '0);
  end

  assign tick = ((state_q == ST_RUN) || (state_q == ST_DONE)) && (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      min_q      <= '0;
      sec_q      <= '0;
      level_q    <= '0;
      tick_cnt_q <= '0;
      duty_q     <= '0;
      dcnt_q     <= '0;
      heater_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      duty_q     <= duty_d;
      dcnt_q     <= dcnt_d;
      // Built from next-state values so heater switches with the state change.
      heater_q   <= (state_d == ST_RUN) && !door && (duty_d <= level_d);
      done_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    level_d    = level_q;
    tick_cnt_d = tick_cnt_q;
    duty_d     = duty_q;
    dcnt_d     = '0;
    if ((state_q == ST_RUN) || (state_q == ST_DONE))
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_p && !door) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
          duty_d     = '0;
          if ((min_q == '0) && (sec_q == '0)) begin
            min_d = MW'(Q_MIN);
            sec_d = 6'(Q_SEC);
          end
        end else if (power_mode) begin
          if (plus_p) begin
            if (level_q != LVL_TOP) level_d = level_q + LW'(1);
          end else if (minus_p) begin
            if (level_q != '0) level_d = level_q - LW'(1);
          end
        end else begin
          min_d = edit_min;
          sec_d = edit_sec;
        end
      end
      ST_RUN: begin
        if (stop_p) begin
          state_d = ST_IDLE;
          min_d   = '0;
          sec_d   = '0;
        end else if (pause_p || door) begin
          state_d = ST_PAUSE;
        end else if (plus_p) begin
          min_d = add_min;
          sec_d = add_sec;
        end else if (tick) begin
          min_d  = tick_min;
          sec_d  = tick_sec;
          duty_d = (duty_q == LVL_TOP) ? '0 : duty_q + LW'(1);
          if (tick_zero) state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop_p) begin
          state_d = ST_IDLE;
          min_d   = '0;
          sec_d   = '0;
        end else if ((start_p || pause_p) && !door) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        min_d  = '0;
        sec_d  = '0;
        dcnt_d = dcnt_q;
        if (start_p || stop_p || pause_p || door) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (tick) begin
          if (dcnt_q == DONE_LAST) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    state  = state_q;
    min    = min_q;
    sec    = sec_q;
    level  = level_q;
    heater = heater_q;
    done   = done_q;
    buzzer = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_microondas_ctrl_param.sv
module tb_microondas_ctrl_param;

  localparam int CF = 4;
  localparam int MM = 99;
  localparam int NL = 4;
  localparam int DS = 3;
  localparam int QS = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, plus = 1'b0, minus = 1'b0;
  logic       door = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       power_mode = 1'b0;
  logic [6:0] dmin;
  logic [5:0] dsec;
  logic [1:0] dlevel, dstate;
  logic       dheater, dbuzzer, ddone;

  microondas_ctrl_param #(
    .CLK_FREQ(CF), .MAX_MIN(MM), .NUM_LEVELS(NL), .DONE_SECS(DS), .QUICK_SEC(QS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .plus(plus), .minus(minus), .door(door), .sel(sel), .power_mode(power_mode),
    .min(dmin), .sec(dsec), .level(dlevel), .heater(dheater), .buzzer(dbuzzer),
    .done(ddone), .state(dstate)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st; int mn; int sc; int lv; int ht; int bz; int dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: time kept as fields for editing, whole seconds for arithmetic.
  int m_st, m_min, m_sec, m_lv, m_tc, m_duty, m_dc;
  int h1[5], h2[5];

  always @(posedge clock) begin : model
    int b[5];
    int a[5];
    int old, tot, step;
    bit tk;
    exp_t e;
    b[0] = int'(start); b[1] = int'(stop); b[2] = int'(pause);
    b[3] = int'(plus);  b[4] = int'(minus);
    if (!reset) begin
      m_st = 0; m_min = 0; m_sec = 0; m_lv = 0; m_tc = 0; m_duty = 0; m_dc = 0;
      for (int i = 0; i < 5; i++) begin h1[i] = 0; h2[i] = 0; end
      e = '{0, 0, 0, 0, 0, 0, 0};
    end else begin
      for (int i = 0; i < 5; i++) begin
        a[i] = (h1[i] == 1 && h2[i] == 0) ? 1 : 0;
        h2[i] = h1[i];
        h1[i] = b[i];
      end
      old = m_st;
      tot = m_min * 60 + m_sec;
      tk  = (m_st == 1 || m_st == 3) && (m_tc == CF - 1);
      if (m_st == 1 || m_st == 3) m_tc = (m_tc + 1) % CF;
      case (m_st)
        0: begin
          if (a[0] == 1 && !door) begin
            if (tot == 0) begin m_min = QS / 60; m_sec = QS % 60; end
            m_st = 1; m_tc = 0; m_duty = 0;
          end else if (power_mode) begin
            if (a[3] == 1) m_lv = (m_lv + 1 > NL - 1) ? NL - 1 : m_lv + 1;
            else if (a[4] == 1) m_lv = (m_lv == 0) ? 0 : m_lv - 1;
          end else begin
            step = (sel == 2'd1 || sel == 2'd3) ? 10 : 1;
            if (sel >= 2'd2) begin
              if (a[3] == 1) m_min = (m_min + step > MM) ? MM : m_min + step;
              else if (a[4] == 1) m_min = (m_min < step) ? 0 : m_min - step;
            end else begin
              if (a[3] == 1) m_sec = (m_sec + step > 59) ? 59 : m_sec + step;
              else if (a[4] == 1) m_sec = (m_sec < step) ? 0 : m_sec - step;
            end
          end
        end
        1: begin
          if (a[1] == 1) begin m_st = 0; m_min = 0; m_sec = 0; end
          else if (a[2] == 1 || door) m_st = 2;
          else if (a[3] == 1) begin
            tot = tot + QS;
            if (tot > MM * 60 + 59) tot = MM * 60 + 59;
            m_min = tot / 60; m_sec = tot % 60;
          end else if (tk) begin
            tot = tot - 1;
            m_min = tot / 60; m_sec = tot % 60;
            m_duty = (m_duty + 1) % NL;
            if (tot == 0) begin m_st = 3; m_dc = 0; end
          end
        end
        2: begin
          if (a[1] == 1) begin m_st = 0; m_min = 0; m_sec = 0; end
          else if ((a[0] == 1 || a[2] == 1) && !door) m_st = 1;
        end
        default: begin
          if (a[0] == 1 || a[1] == 1 || a[2] == 1 || door) m_st = 0;
          else if (tk) begin
            m_dc++;
            if (m_dc == DS) m_st = 0;
          end
        end
      endcase
      e.st = m_st; e.mn = m_min; e.sc = m_sec; e.lv = m_lv;
      e.ht = (m_st == 1 && !door && m_duty <= m_lv) ? 1 : 0;
      e.bz = (m_st == 3) ? 1 : 0;
      e.dn = (m_st == 3 && old != 3) ? 1 : 0;
    end
    q.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_state",  int'(dstate),  e.st);
      chk("sb_min",    int'(dmin),    e.mn);
      chk("sb_sec",    int'(dsec),    e.sc);
      chk("sb_level",  int'(dlevel),  e.lv);
      chk("sb_heater", int'(dheater), e.ht);
      chk("sb_buzzer", int'(dbuzzer), e.bz);
      chk("sb_done",   int'(ddone),   e.dn);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: start = v;
      1: stop  = v;
      2: pause = v;
      3: plus  = v;
      default: minus = v;
    endcase
  endtask

  // Button high for one cycle; returns just after the edge that acts on it.
  task automatic press(input int idx, input int times);
    for (int k = 0; k < times; k++) begin
      set_btn(idx, 1'b1);
      cyc(1);
      set_btn(idx, 1'b0);
      cyc(1);
    end
  endtask

  initial begin
    // 1: reset and saturating edits
    reset = 1'b0;
    cyc(2);
    chk("rst_state", int'(dstate), 0);
    chk("rst_min", int'(dmin), 0);
    chk("rst_sec", int'(dsec), 0);
    chk("rst_heater", int'(dheater), 0);
    reset = 1'b1;
    cyc(1);
    sel = 2'd1; press(3, 7);
    chk("edit_sec_sat", int'(dsec), 59);
    sel = 2'd3; press(4, 1);
    chk("edit_min_floor", int'(dmin), 0);

    // 2: 0:02 countdown into DONE
    sel = 2'd1; press(4, 6);
    sel = 2'd0; press(3, 2);
    chk("set_sec2", int'(dsec), 2);
    press(0, 1);
    chk("run_state", int'(dstate), 1);
    cyc(4);
    chk("tick1_sec", int'(dsec), 1);
    cyc(4);
    chk("done_state", int'(dstate), 3);
    chk("done_pulse", int'(ddone), 1);
    chk("done_buzzer", int'(dbuzzer), 1);
    cyc(1);
    chk("done_pulse_end", int'(ddone), 0);
    cyc(10);
    chk("done_hold", int'(dstate), 3);
    cyc(1);
    chk("done_exit", int'(dstate), 0);

    // 3: quick start and saturating add
    press(0, 1);
    chk("quick_sec", int'(dsec), 30);
    chk("quick_state", int'(dstate), 1);
    press(1, 1);
    sel = 2'd3; press(3, 10);
    sel = 2'd1; press(3, 5);
    chk("set_min99", int'(dmin), 99);
    chk("set_sec50", int'(dsec), 50);
    press(0, 1);
    press(3, 1);
    chk("add_sat_min", int'(dmin), 99);
    chk("add_sat_sec", int'(dsec), 59);
    press(1, 1);

    // 4: door interlock and resume
    sel = 2'd2; press(3, 1);
    press(0, 1);
    door = 1'b1;
    cyc(1);
    chk("door_pause", int'(dstate), 2);
    chk("door_heater", int'(dheater), 0);
    press(0, 1);
    chk("door_start_ign", int'(dstate), 2);
    door = 1'b0;
    press(0, 1);
    chk("resume_state", int'(dstate), 1);
    cyc(2);
    chk("resume_hold_sec", int'(dsec), 0);
    cyc(1);
    chk("resume_tick_min", int'(dmin), 0);
    chk("resume_tick_sec", int'(dsec), 59);
    press(1, 1);

    // 5: duty cycle at level 1 and level 3
    power_mode = 1'b1; press(3, 1); power_mode = 1'b0;
    chk("level1", int'(dlevel), 1);
    press(0, 1);
    for (int k = 0; k < 32; k++) begin
      chk("duty_l1", int'(dheater), (((k / 4) % 4) <= 1) ? 1 : 0);
      cyc(1);
    end
    press(1, 1);
    power_mode = 1'b1; press(3, 2); power_mode = 1'b0;
    chk("level3", int'(dlevel), 3);
    press(0, 1);
    for (int k = 0; k < 16; k++) begin
      chk("duty_l3", int'(dheater), 1);
      cyc(1);
    end

    // 6: stop beats pause; mid-run reset
    stop = 1'b1; pause = 1'b1;
    cyc(1);
    stop = 1'b0; pause = 1'b0;
    cyc(1);
    chk("stop_prio_state", int'(dstate), 0);
    chk("stop_prio_sec", int'(dsec), 0);
    press(0, 1);
    cyc(5);
    reset = 1'b0;
    cyc(1);
    chk("midrst_state", int'(dstate), 0);
    chk("midrst_sec", int'(dsec), 30 - 30);
    chk("midrst_level", int'(dlevel), 0);
    chk("midrst_heater", int'(dheater), 0);
    reset = 1'b1;
    cyc(2);

    // Random phase A: everything toggles
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 59) == 0);
      plus  = ($urandom_range(0, 19) == 0);
      minus = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) door = ~door;
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) power_mode = ~power_mode;
      reset = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    // Random phase B: sparse control buttons so countdowns reach DONE
    plus = 1'b0; minus = 1'b0; reset = 1'b1; door = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 399) == 0);
      pause = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) door = ~door;
      cyc(1);
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; door = 1'b0;
    cyc(2);
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
